// File: rtl/if_fetch_queue_if.sv
// Fetch front-end signal bundle: redirect, imem request/response channel and the decode-side handshake.
// master = fetch queue; slave = branch unit / instruction memory / decode side.
interface if_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
        input  imem_resp_valid, imem_resp_data, id_ready,
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
        output imem_resp_valid, imem_resp_data, id_ready,
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/if_fetch_queue.sv
// RV32I fetch front end: sequential PC generation, in-order prefetch queue, redirect flush with response dropping.
// Latency: response to id_valid 1 cycle (0 cycles from an empty queue when FETCH_BYPASS_EN is defined).
// Backpressure: requests are issued only while queued + live in-flight entries < DEPTH; decode stalls via id_ready.
module if_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.master bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned OW  = $clog2(2 * DEPTH + 1);
    localparam int unsigned PD  = 2 * DEPTH;
    localparam int unsigned PAW = $clog2(PD);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [OW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PAW-1:0] pcf_rd_q, pcf_rd_d;
    logic [PAW-1:0] pcf_wr_q, pcf_wr_d;

    logic [31:0]    q_pc_q    [DEPTH];
    logic [31:0]    q_pc_d    [DEPTH];
    logic [31:0]    q_instr_q [DEPTH];
    logic [31:0]    q_instr_d [DEPTH];
    logic [31:0]    pcf_q     [PD];
    logic [31:0]    pcf_d     [PD];

    logic           q_empty;
    logic           q_full;
    logic           credit_ok;
    logic           req_fire;
    logic           resp_fire;
    logic           resp_keep;
    logic           bypass;
    logic           push;
    logic           pop;
    logic [OW-1:0]  in_use;
    logic [31:0]    resp_pc;

    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == CW'(DEPTH));
    assign resp_pc   = pcf_q[pcf_rd_q];

    // Live demand = queued entries + in-flight responses that will be kept.
    // The outstanding cap only bounds the PC FIFO under pathological back-to-back redirects.
    assign in_use    = OW'(count_q) + outstanding_q - drop_cnt_q;
    assign credit_ok = (in_use < OW'(DEPTH)) && (outstanding_q < OW'(PD));

    assign bus.imem_req_valid = !rst && credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_fire = bus.imem_resp_valid;
    assign resp_keep = resp_fire && (state_q == FETCH) && !bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_keep && !(bypass && bus.id_ready);
    assign pop  = !q_empty && bus.id_ready && !bus.redirect_valid;

    always_comb begin
        bus.id_valid = 1'b0;
        bus.id_pc    = '0;
        bus.id_instr = NOP_INSTR;
        if (!q_empty) begin
            bus.id_valid = 1'b1;
            bus.id_pc    = q_pc_q[rd_ptr_q];
            bus.id_instr = q_instr_q[rd_ptr_q];
        end else if (bypass) begin
            bus.id_valid = 1'b1;
            bus.id_pc    = resp_pc;
            bus.id_instr = bus.imem_resp_data;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);
        drop_cnt_d    = drop_cnt_q;
        pcf_wr_d      = pcf_wr_q + PAW'(req_fire);
        pcf_rd_d      = pcf_rd_q + PAW'(resp_fire);
        pcf_d         = pcf_q;
        if (req_fire) begin
            pcf_d[pcf_wr_q] = fetch_pc_q;
        end

        // Every response still owed after a redirect belongs to the stale path.
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_fire && (state_q == DRAIN)) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
        end

        state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;
        if (bus.redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]    = resp_pc;
                q_instr_d[wr_ptr_q] = bus.imem_resp_data;
            end
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pcf_rd_q      <= '0;
            pcf_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pcf_rd_q      <= pcf_rd_d;
            pcf_wr_q      <= pcf_wr_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
        pcf_q     <= pcf_d;
    end

    a_no_resp_into_full_queue: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_resp_valid && (drop_cnt_q == '0) && q_full));

    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_resp_valid && (outstanding_q == '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios with literal expectations plus randomized traffic,
// all checked each cycle against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    if_fetch_queue_if bus ();

    if_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          c_rst, c_redir, c_ready, c_id_ready, c_rand;
    logic [31:0] c_redir_pc;
    int          c_lat;

    typedef struct { int t; logic [31:0] data; } mem_t;
    mem_t memq[$];
    int   last_t = 0;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] pc; bit keep; } pend_t;
    ent_t        mq[$];
    pend_t       pend[$];
    logic [31:0] m_pc;
    bit          m_init = 0;

    logic        s_req_valid, s_id_valid;
    logic [31:0] s_addr, s_id_pc, s_id_instr;

    logic [31:0] consumed_pc[$];
    int          consumed_cyc[$];
    logic [31:0] acc_addr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int keep_cnt();
        int k = 0;
        foreach (pend[i]) if (pend[i].keep) k++;
        return k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic set_ctl(input bit r, input bit rd, input logic [31:0] pc,
                           input bit rdy, input bit idr, input int lat);
        c_rst = r; c_redir = rd; c_redir_pc = pc;
        c_ready = rdy; c_id_ready = idr; c_lat = lat;
    endtask

    task automatic clear_logs();
        consumed_pc.delete();
        consumed_cyc.delete();
        acc_addr.delete();
    endtask

    task automatic step();
        logic        rv;
        logic [31:0] rd, rpc, e_addr, e_idpc, e_idinstr;
        bit          e_req, e_idv, bypass_ok, acc, kept, popped;
        int          t;
        @(negedge clk);
        if (c_rand) begin
            c_rst      = ($urandom_range(0, 299) == 0);
            c_redir    = ($urandom_range(0, 19) == 0);
            c_redir_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_03FF);
            c_ready    = ($urandom_range(0, 3) != 0);
            c_id_ready = ($urandom_range(0, 2) != 0);
            c_lat      = $urandom_range(1, 4);
        end
        rv = 1'b0;
        rd = '0;
        if (!c_rst && memq.size() > 0 && memq[0].t <= cyc) begin
            rv = 1'b1;
            rd = memq[0].data;
            void'(memq.pop_front());
        end
        rst                 = c_rst;
        bus.redirect_valid  = c_redir;
        bus.redirect_pc     = c_redir_pc;
        bus.imem_req_ready  = c_ready;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rd;
        bus.id_ready        = c_id_ready;
        #1;
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_req_addr;
        s_id_valid  = bus.id_valid;
        s_id_pc     = bus.id_pc;
        s_id_instr  = bus.id_instr;

        // Reference expectations for this cycle.
        e_req     = !c_rst && (mq.size() + keep_cnt() < DEPTH) && (pend.size() < 2 * DEPTH);
        e_addr    = m_pc;
        bypass_ok = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass_ok = rv && !c_redir && mq.size() == 0 && pend.size() > 0 && pend[0].keep;
`endif
        if (mq.size() > 0) begin
            e_idv = 1'b1; e_idpc = mq[0].pc; e_idinstr = mq[0].instr;
        end else if (bypass_ok) begin
            e_idv = 1'b1; e_idpc = pend[0].pc; e_idinstr = mem_word(pend[0].pc);
        end else begin
            e_idv = 1'b0; e_idpc = '0; e_idinstr = NOP;
        end
        if (m_init) begin
            chk("req_valid", 32'(s_req_valid), 32'(e_req));
            chk("req_addr", s_addr, e_addr);
            chk("id_valid", 32'(s_id_valid), 32'(e_idv));
            chk("id_pc", s_id_pc, e_idpc);
            chk("id_instr", s_id_instr, e_idinstr);
        end

        // Memory follows what the DUT actually issued.
        if (s_req_valid && c_ready) begin
            t = (cyc + c_lat > last_t + 1) ? cyc + c_lat : last_t + 1;
            last_t = t;
            memq.push_back('{t: t, data: mem_word(s_addr)});
            acc_addr.push_back(s_addr);
        end

        if (c_rst) begin
            m_init = 1'b1;
            m_pc   = RESET_PC;
            mq.delete();
            pend.delete();
            memq.delete();
            last_t = cyc;
        end else if (m_init) begin
            acc  = e_req && c_ready;
            kept = 1'b0;
            rpc  = '0;
            if (rv) begin
                chk("resp_has_request", 32'(pend.size() > 0), 32'd1);
                if (pend.size() > 0) begin
                    kept = pend[0].keep && !c_redir;
                    rpc  = pend[0].pc;
                    void'(pend.pop_front());
                end
            end
            if (c_redir) begin
                mq.delete();
                foreach (pend[i]) pend[i].keep = 1'b0;
                if (acc) pend.push_back('{pc: m_pc, keep: 1'b0});
                m_pc = c_redir_pc & 32'hFFFF_FFFC;
            end else begin
                popped = (mq.size() > 0) && c_id_ready;
                if (popped) begin
                    consumed_pc.push_back(mq[0].pc);
                    consumed_cyc.push_back(cyc);
                end
                if (kept) begin
                    if (bypass_ok && c_id_ready) begin
                        consumed_pc.push_back(rpc);
                        consumed_cyc.push_back(cyc);
                    end else begin
                        mq.push_back('{pc: rpc, instr: mem_word(rpc)});
                    end
                end
                if (popped) void'(mq.pop_front());
                if (acc) begin
                    pend.push_back('{pc: m_pc, keep: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    logic [31:0] exp_wrap [3];

    initial begin
        c_rand = 1'b0;
        exp_wrap[0] = 32'hFFFF_FFF8;
        exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000;

        // Reset state, then 1-cycle memory streaming into a always-ready decoder.
        set_ctl(1, 0, 0, 0, 0, 1); step(); step();
        chk("rst_req_valid", 32'(s_req_valid), 32'd0);
        chk("rst_id_valid", 32'(s_id_valid), 32'd0);
        chk("rst_id_pc", s_id_pc, 32'd0);
        chk("rst_id_instr", s_id_instr, 32'h13);
        chk("rst_addr", s_addr, RESET_PC);
        clear_logs();
        set_ctl(0, 0, 0, 1, 1, 1); step();
        chk("A_first_req", 32'(s_req_valid), 32'd1);
        repeat (11) step();
        for (int i = 0; i < 4; i++) chk("A_pc", consumed_pc[i], 32'(4 * i));
        for (int i = 0; i < 3; i++) chk("A_gap", 32'(consumed_cyc[i+1] - consumed_cyc[i]), 32'd1);

        // Decoder stalled: exactly DEPTH requests, then drain in order.
        set_ctl(1, 0, 0, 0, 0, 1); step();
        clear_logs();
        set_ctl(0, 0, 0, 1, 0, 1); repeat (12) step();
        chk("B_accepts", 32'(acc_addr.size()), 32'd4);
        chk("B_req_valid", 32'(s_req_valid), 32'd0);
        set_ctl(0, 0, 0, 1, 1, 1); repeat (8) step();
        for (int i = 0; i < 4; i++) chk("B_pc", consumed_pc[i], 32'(4 * i));

        // Redirect with two requests in flight on a 3-cycle memory.
        set_ctl(1, 0, 0, 0, 0, 3); step();
        clear_logs();
        set_ctl(0, 0, 0, 1, 0, 3); step(); step();
        set_ctl(0, 1, 32'h100, 0, 0, 3); step();
        set_ctl(0, 0, 0, 1, 1, 3); repeat (14) step();
        chk("C_pc0", consumed_pc[0], 32'h100);
        chk("C_pc1", consumed_pc[1], 32'h104);

        // Redirect coinciding with a response, unaligned target.
        set_ctl(1, 0, 0, 0, 0, 2); step();
        clear_logs();
        set_ctl(0, 0, 0, 1, 1, 2); step();
        set_ctl(0, 0, 0, 0, 1, 2); step();
        set_ctl(0, 1, 32'h203, 0, 1, 2); step();
        set_ctl(0, 0, 0, 1, 1, 1); step();
        chk("D_addr", s_addr, 32'h200);
        chk("D_req_valid", 32'(s_req_valid), 32'd1);
        repeat (8) step();
        chk("D_pc0", consumed_pc[0], 32'h200);
        chk("D_pc1", consumed_pc[1], 32'h204);

        // Address wrap-around.
        set_ctl(1, 0, 0, 0, 0, 1); step();
        set_ctl(0, 1, 32'hFFFF_FFF8, 0, 1, 1); step();
        clear_logs();
        set_ctl(0, 0, 0, 1, 1, 1); repeat (6) step();
        for (int i = 0; i < 3; i++) chk("E_addr", acc_addr[i], exp_wrap[i]);

        // Reset mid-stream with three queued entries.
        set_ctl(1, 0, 0, 0, 0, 1); step();
        set_ctl(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 20 && mq.size() < 3; i++) step();
        chk("F_queued", 32'(mq.size()), 32'd3);
        step();
        set_ctl(1, 0, 0, 1, 0, 1); step();
        set_ctl(0, 0, 0, 1, 0, 1); step();
        chk("F_id_valid", 32'(s_id_valid), 32'd0);
        chk("F_id_instr", s_id_instr, 32'h13);
        chk("F_req_valid", 32'(s_req_valid), 32'd1);
        chk("F_addr", s_addr, RESET_PC);

        // Randomized traffic against the reference model.
        set_ctl(1, 0, 0, 0, 0, 1); step();
        c_rand = 1'b1;
        repeat (3000) step();
        c_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
